// File: rtl/irqc_pkg.sv
// Shared constants and types for the interrupt controller.
package irqc_pkg;

  localparam int unsigned CODE_W = 3;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int unsigned STAT_INSERV_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    INJECT,
    IN_SERVICE
  } irqc_state_e;

endpackage

// File: rtl/irq_controller_edge_detect.sv
// Per-source rising-edge detector; IRQ_SYNC_EN adds a 2-flop synchronizer in front.
module irq_edge_detect #(
  parameter int unsigned N_SRC = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  output logic [N_SRC-1:0] irq_rise
);

  logic [N_SRC-1:0] irq_s;
  logic [N_SRC-1:0] prev_q;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_q;
  logic [N_SRC-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // History resets to 0 so a line already high out of reset counts as one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= irq_s;
    end
  end

  assign irq_rise = irq_s & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched pending bits, mask, GIE, one-cycle code injection.
// Optional macro IRQ_SYNC_EN enables input synchronizers in irq_edge_detect.
module irq_controller
  import irqc_pkg::*;
#(
  parameter int unsigned N_SRC = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              cpu_ready,
  input  logic              reti,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic [7:0]        cfg_rdata,
  output logic [CODE_W-1:0] irq_code,
  output logic              in_service
);

  irqc_state_e       state_q, state_d;
  logic [N_SRC-1:0]  mask_q, mask_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic              gie_q, gie_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] active_q, active_d;

  logic [N_SRC-1:0]  irq_rise;
  logic [N_SRC-1:0]  elig;
  logic [CODE_W-1:0] win;
  logic              fire;
  logic [N_SRC-1:0]  fire_clr;
  logic              unused_wdata;

  irq_edge_detect #(
    .N_SRC (N_SRC)
  ) u_edge (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .irq_rise (irq_rise)
  );

  assign elig = pend_q & mask_q;

  // Lowest eligible index wins.
  always_comb begin
    win = '0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      if (elig[k]) begin
        win = CODE_W'(k);
      end
    end
  end

  assign fire     = (state_q == IDLE) && gie_q && cpu_ready && (|elig);
  assign fire_clr = fire ? (N_SRC'(1) << win) : '0;

  always_comb begin
    state_d  = state_q;
    code_d   = '0;
    active_d = active_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d  = INJECT;
          code_d   = win + CODE_W'(1);
          active_d = win + CODE_W'(1);
        end
      end
      INJECT: begin
        state_d = IN_SERVICE;
      end
      IN_SERVICE: begin
        if (reti) begin
          state_d  = IDLE;
          active_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // New edges are OR-ed in last so a set beats a same-cycle W1C.
  always_comb begin
    mask_d = mask_q;
    gie_d  = gie_q;
    pend_d = pend_q & ~fire_clr;
    if (cfg_we) begin
      unique case (cfg_addr)
        ADDR_MASK: mask_d = cfg_wdata[N_SRC-1:0];
        ADDR_PEND: pend_d = pend_d & ~cfg_wdata[N_SRC-1:0];
        ADDR_CTRL: gie_d  = cfg_wdata[0];
        default:   ;
      endcase
    end
    pend_d = pend_d | irq_rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      pend_q   <= '0;
      gie_q    <= 1'b0;
      code_q   <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      gie_q    <= gie_d;
      code_q   <= code_d;
      active_q <= active_d;
    end
  end

  assign irq_code   = code_q;
  assign in_service = (state_q != IDLE);

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      ADDR_MASK: cfg_rdata[N_SRC-1:0] = mask_q;
      ADDR_PEND: cfg_rdata[N_SRC-1:0] = pend_q;
      ADDR_STAT: begin
        cfg_rdata[STAT_INSERV_BIT] = in_service;
        cfg_rdata[CODE_W-1:0]      = active_q;
      end
      ADDR_CTRL: cfg_rdata[0] = gie_q;
      default:   ;
    endcase
  end

  assign unused_wdata = ^cfg_wdata[7:N_SRC];

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed vector table, bounded sequence, random vs model.
module tb_irq_controller;

  logic       clk;
  logic       reset;
  logic [6:0] irq_in;
  logic       cpu_ready;
  logic       reti;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic [2:0] irq_code;
  logic       in_service;

  int total = 0;
  int bad   = 0;

  irq_controller #(
    .N_SRC (7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .cpu_ready  (cpu_ready),
    .reti       (reti),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .irq_code   (irq_code),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rst;
    int irq;
    int rdy;
    int rt;
    int we;
    int addr;
    int wdata;
    int code;
    int insv;
    int rdata;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: phase 0 idle, 1 code issued, 2 servicing.
  int m_mask, m_pend, m_gie, m_phase, m_code, m_active, m_prev;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int rst, input int irq, input int rdy, input int rt,
                            input int we, input int addr, input int wdata);
    int rise, elig, win, np;
    if (rst != 0) begin
      m_mask = 0; m_pend = 0; m_gie = 0; m_phase = 0;
      m_code = 0; m_active = 0; m_prev = 0;
      return;
    end
    rise   = irq & ~m_prev & 'h7f;
    m_prev = irq;
    elig   = m_pend & m_mask;
    win    = -1;
    for (int k = 6; k >= 0; k--) if (((elig >> k) & 1) != 0) win = k;
    np = m_pend;
    if (we != 0 && addr == 1) np = np & ~wdata;
    if (m_phase == 0 && m_gie != 0 && rdy != 0 && win >= 0) begin
      np       = np & ~(1 << win);
      m_code   = win + 1;
      m_active = win + 1;
      m_phase  = 1;
    end else begin
      m_code = 0;
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && rt != 0) begin
        m_phase  = 0;
        m_active = 0;
      end
    end
    m_pend = (np | rise) & 'h7f;
    if (we != 0 && addr == 0) m_mask = wdata & 'h7f;
    if (we != 0 && addr == 3) m_gie = wdata & 1;
  endtask

  function automatic int m_read(input int addr);
    case (addr)
      0:       return m_mask;
      1:       return m_pend;
      2:       return ((m_phase != 0) ? 'h80 : 0) | m_active;
      default: return m_gie;
    endcase
  endfunction

  task automatic drive(input int rst, input int irq, input int rdy, input int rt,
                       input int we, input int addr, input int wdata);
    reset     = (rst != 0);
    irq_in    = 7'(irq);
    cpu_ready = (rdy != 0);
    reti      = (rt != 0);
    cfg_we    = (we != 0);
    cfg_addr  = 2'(addr);
    cfg_wdata = 8'(wdata);
  endtask

  // rst irq rdy reti we addr wdata | code insv rdata
  function automatic void add(input int rst, input int irq, input int rdy, input int rt,
                              input int we, input int addr, input int wdata,
                              input int code, input int insv, input int rdata);
    vecs.push_back('{rst, irq, rdy, rt, we, addr, wdata, code, insv, rdata});
  endfunction

  initial begin
    int found;
    drive(1, 0, 0, 0, 0, 0, 0);

    add(1, 'h00, 1, 0, 0, 0, 'h00, 0, 0, 'h00);  // reset, MASK=0
    add(0, 'h00, 1, 0, 1, 0, 'h7f, 0, 0, 'h7f);  // MASK=7F
    add(0, 'h00, 1, 0, 1, 3, 'hff, 0, 0, 'h01);  // GIE=1, other bits read 0
    add(0, 'h04, 1, 0, 0, 1, 'h00, 0, 0, 'h04);  // edge on src2 latched
    add(0, 'h00, 1, 0, 0, 2, 'h00, 3, 1, 'h83);  // code 3 issued
    add(0, 'h00, 1, 0, 0, 1, 'h00, 0, 1, 'h00);  // one cycle only, pending cleared
    add(0, 'h00, 1, 1, 0, 2, 'h00, 0, 0, 'h00);  // reti
    add(0, 'h12, 1, 0, 0, 1, 'h00, 0, 0, 'h12);  // src4 and src1 together
    add(0, 'h00, 1, 0, 0, 2, 'h00, 2, 1, 'h82);  // lowest wins
    add(0, 'h00, 1, 0, 0, 1, 'h00, 0, 1, 'h10);
    add(0, 'h00, 1, 1, 0, 2, 'h00, 0, 0, 'h00);
    add(0, 'h00, 1, 0, 0, 2, 'h00, 5, 1, 'h85);  // second source after reti
    add(0, 'h00, 1, 1, 0, 2, 'h00, 0, 1, 'h85);  // reti during INJECT ignored
    add(0, 'h00, 1, 1, 0, 1, 'h00, 0, 0, 'h00);
    add(0, 'h00, 1, 0, 1, 0, 'h00, 0, 0, 'h00);  // MASK=0
    add(0, 'h01, 1, 0, 0, 1, 'h00, 0, 0, 'h01);  // masked still latches
    add(0, 'h00, 1, 0, 0, 1, 'h00, 0, 0, 'h01);
    add(0, 'h00, 1, 0, 1, 0, 'h01, 0, 0, 'h01);  // unmask src0
    add(0, 'h00, 1, 0, 0, 2, 'h00, 1, 1, 'h81);
    add(0, 'h00, 1, 0, 0, 2, 'h00, 0, 1, 'h81);
    add(0, 'h40, 1, 0, 1, 0, 'h7f, 0, 1, 'h7f);  // edge during service
    add(0, 'h00, 1, 0, 0, 1, 'h00, 0, 1, 'h40);
    add(0, 'h00, 1, 1, 0, 2, 'h00, 0, 0, 'h00);
    add(0, 'h00, 1, 0, 0, 2, 'h00, 7, 1, 'h87);
    add(0, 'h00, 1, 0, 0, 2, 'h00, 0, 1, 'h87);
    add(0, 'h00, 1, 1, 0, 2, 'h00, 0, 0, 'h00);
    add(0, 'h00, 1, 1, 0, 2, 'h00, 0, 0, 'h00);  // reti while idle
    add(0, 'h00, 1, 0, 1, 0, 'h00, 0, 0, 'h00);
    add(0, 'h04, 1, 0, 0, 1, 'h00, 0, 0, 'h04);
    add(0, 'h00, 1, 0, 0, 1, 'h00, 0, 0, 'h04);
    add(0, 'h04, 1, 0, 1, 1, 'h04, 0, 0, 'h04);  // set beats W1C
    add(0, 'h00, 1, 0, 1, 1, 'h04, 0, 0, 'h00);  // plain W1C
    add(0, 'h00, 0, 0, 1, 0, 'h7f, 0, 0, 'h7f);
    add(0, 'h08, 0, 0, 0, 1, 'h00, 0, 0, 'h08);  // cpu_ready low
    add(0, 'h00, 0, 0, 0, 1, 'h00, 0, 0, 'h08);
    add(0, 'h00, 0, 0, 0, 1, 'h00, 0, 0, 'h08);
    add(0, 'h00, 0, 0, 0, 1, 'h00, 0, 0, 'h08);
    add(0, 'h00, 0, 0, 0, 1, 'h00, 0, 0, 'h08);
    add(0, 'h00, 1, 0, 0, 2, 'h00, 4, 1, 'h84);  // ready again
    add(1, 'h00, 1, 0, 0, 2, 'h00, 0, 0, 'h00);  // reset during INJECT
    add(0, 'h00, 1, 0, 0, 0, 'h00, 0, 0, 'h00);
    add(0, 'h00, 1, 0, 0, 1, 'h00, 0, 0, 'h00);
    add(0, 'h00, 1, 0, 0, 3, 'h00, 0, 0, 'h00);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].irq, vecs[i].rdy, vecs[i].rt,
            vecs[i].we, vecs[i].addr, vecs[i].wdata);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_code", i), int'(irq_code), vecs[i].code);
      check($sformatf("vec%0d_insv", i), int'(in_service), vecs[i].insv);
      check($sformatf("vec%0d_rdata", i), int'(cfg_rdata), vecs[i].rdata);
    end

    // Bounded wait for a single dispatch, then confirm it lasts one cycle.
    drive(1, 0, 1, 0, 0, 0, 0);    @(posedge clk); #1;
    drive(0, 0, 1, 0, 1, 0, 'h7f); @(posedge clk); #1;
    drive(0, 0, 1, 0, 1, 3, 'h01); @(posedge clk); #1;
    drive(0, 'h20, 1, 0, 0, 2, 0); @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 2, 0);
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(posedge clk); #1;
      if (irq_code != 3'd0) found = 1;
    end
    check("wait_dispatch", found, 1);
    check("wait_code", int'(irq_code), 6);
    @(posedge clk); #1;
    check("wait_code_drop", int'(irq_code), 0);
    check("wait_insv", int'(in_service), 1);

    // Randomized run against the reference model.
    drive(1, 0, 1, 0, 0, 0, 0);
    model_step(1, 0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 600; c++) begin
      int rst, irq, rdy, rt, we, addr, wdata;
      rst   = ($urandom_range(99) < 2) ? 1 : 0;
      irq   = ($urandom_range(3) == 0) ? int'($urandom_range(127)) : int'(irq_in);
      rdy   = ($urandom_range(3) != 0) ? 1 : 0;
      rt    = ($urandom_range(4) == 0) ? 1 : 0;
      we    = ($urandom_range(5) == 0) ? 1 : 0;
      addr  = int'($urandom_range(3));
      wdata = int'($urandom_range(255));
      if (we != 0 && addr == 3 && $urandom_range(3) != 0) wdata = wdata | 1;
      drive(rst, irq, rdy, rt, we, addr, wdata);
      model_step(rst, irq, rdy, rt, we, addr, wdata);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_code", c), int'(irq_code), m_code);
      check($sformatf("rnd%0d_insv", c), int'(in_service), (m_phase != 0) ? 1 : 0);
      check($sformatf("rnd%0d_rdata", c), int'(cfg_rdata), m_read(addr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
